mem_port_arbiter: RTL and testbench

//  Shares the CPU's single-port unified memory between the multicycle control FSM (cpu_*) and
//  the debug/program loader (dbg_*). Serializes accesses, inserts read wait-states, returns
//  one-cycle acks. Sits between both requesters and the memory macro; only mem_* drives memory.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of mem_port_arbiter bundled as one interface.
// The arbiter connects through the slave modport; a requester/memory harness uses master.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_ack, dbg_ack, rdata, mem_addr, mem_we, mem_wdata, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_ack, dbg_ack, rdata, mem_addr, mem_we, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serializes cpu and debug-loader accesses onto one single-port memory, with read
// wait-states, bounded debug starvation and a one-cycle ack per completed access.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [SW-1:0] SMAX      = SW'(STARVE_MAX);
    localparam logic [WW-1:0] WAIT_INIT = WW'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

    state_e        state_q, state_d;
    logic          owner_dbg_q, owner_dbg_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          grant_dbg;

    // Debug only preempts a waiting cpu once it has been passed over STARVE_MAX times.
    assign grant_dbg = bus.dbg_req && (!bus.cpu_req || (starve_cnt_q == SMAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_dbg_q  <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            starve_cnt_q <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_dbg_q  <= owner_dbg_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            starve_cnt_q <= starve_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_dbg_d  = owner_dbg_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        starve_cnt_d = starve_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.dbg_req) begin
                    owner_dbg_d = grant_dbg;
                    we_d        = grant_dbg ? bus.dbg_we    : bus.cpu_we;
                    addr_d      = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
                    wdata_d     = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                    if (grant_dbg || !bus.dbg_req)
                        starve_cnt_d = '0;
                    else if (starve_cnt_q != SMAX)
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    wait_cnt_d = WAIT_INIT;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // Last wait cycle is exactly RD_LAT cycles after the address went out.
                if (wait_cnt_q == '0) begin
                    rdata_d = bus.mem_rdata;
                    state_d = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = (state_q == ACCESS) && we_q;
    assign bus.cpu_ack   = (state_q == DONE) && !owner_dbg_q;
    assign bus.dbg_ack   = (state_q == DONE) && owner_dbg_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level arbitration/memory model.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) ifc ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) ifc3 ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .reset(reset), .bus(ifc));
    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .STARVE_MAX(SMAX)) u_dut3 (
        .clk(clk), .reset(reset), .bus(ifc3));

    // Memory macro model for the RD_LAT=1 instance: synchronous read, one cycle latency.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] mem_rdata_r;
    logic          pre_en;
    logic [7:0]    pre_addr;
    logic [DW-1:0] pre_data;
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (ifc.mem_we) mem[ifc.mem_addr[7:0]] <= ifc.mem_wdata;
        mem_rdata_r <= mem[ifc.mem_addr[7:0]];
    end
    assign ifc.mem_rdata = mem_rdata_r;

    logic [DW-1:0] rdata3_drv;
    assign ifc3.mem_rdata = rdata3_drv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1 pre_en = 1'b0;
    endtask

    task automatic set_req(input bit is_dbg, input bit req, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (is_dbg) begin
            ifc.dbg_req = req; ifc.dbg_we = we; ifc.dbg_addr = a; ifc.dbg_wdata = d;
        end else begin
            ifc.cpu_req = req; ifc.cpu_we = we; ifc.cpu_addr = a; ifc.cpu_wdata = d;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_ack", ifc.cpu_ack, 0);
        chk("rst_dbg_ack", ifc.dbg_ack, 0);
        chk("rst_mem_we", ifc.mem_we, 0);
        chk("rst_mem_addr", ifc.mem_addr, 0);
        chk("rst_mem_wdata", ifc.mem_wdata, 0);
        chk("rst_rdata", ifc.rdata, 0);
        chk("rst_busy", ifc.busy, 0);
        @(posedge clk); #1 reset = 1'b0;
    endtask

    // Starts and ends one cycle-boundary past posedge; cycle 0 is the IDLE cycle seeing req.
    task automatic run_txn(input bit is_dbg, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd,
                           output int other_acks, output int we_cnt);
        set_req(is_dbg, 1'b1, we, a, d);
        lat = -1; rd = '0; other_acks = 0; we_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ifc.mem_we && ifc.mem_addr == a) we_cnt++;
            if (is_dbg ? ifc.cpu_ack : ifc.dbg_ack) other_acks++;
            if (is_dbg ? ifc.dbg_ack : ifc.cpu_ack) begin
                lat = n; rd = ifc.rdata;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        set_req(is_dbg, 1'b0, 1'b0, '0, '0);
    endtask

    typedef struct {
        bit            is_dbg;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            exp_lat;
        logic [DW-1:0] exp_rdata;
    } vec_t;
    vec_t vt [8];

    typedef struct {
        bit            we;
        logic [3:0]    a;
        logic [DW-1:0] d;
    } txn_t;

    bit            creq_h [4096];
    bit            dreq_h [4096];
    logic [DW-1:0] refm   [16];

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, oth, wec, n_acks, k, prev_ack, mstarve, eg, g;
        logic [DW-1:0] rd;
        bit order [10];
        int ack_cyc [4];
        int both;
        bit addr_ok, c_pend, d_pend, c_ackd, d_ackd, is_d, pick_d;
        txn_t ctx, dtx, tx;

        reset = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0; rdata3_drv = '0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        ifc3.cpu_req = 0; ifc3.cpu_we = 0; ifc3.cpu_addr = '0; ifc3.cpu_wdata = '0;
        ifc3.dbg_req = 0; ifc3.dbg_we = 0; ifc3.dbg_addr = '0; ifc3.dbg_wdata = '0;

        do_reset();
        preload(8'h10, 32'hDEADBEEF);

        // Vector table: single requester at a time; rdata holds the last read over writes.
        vt[0] = '{0, 0, 32'h10, 32'h0,        3, 32'hDEADBEEF};
        vt[1] = '{0, 1, 32'h20, 32'h1234,     2, 32'hDEADBEEF};
        vt[2] = '{1, 1, 32'h21, 32'hA5A50001, 2, 32'hDEADBEEF};
        vt[3] = '{1, 0, 32'h20, 32'h0,        3, 32'h1234};
        vt[4] = '{0, 0, 32'h21, 32'h0,        3, 32'hA5A50001};
        vt[5] = '{0, 1, 32'hFF, 32'hFFFFFFFF, 2, 32'hA5A50001};
        vt[6] = '{1, 0, 32'hFF, 32'h0,        3, 32'hFFFFFFFF};
        vt[7] = '{0, 1, 32'h00, 32'h0,        2, 32'hFFFFFFFF};
        for (int i = 0; i < 8; i++) begin
            run_txn(vt[i].is_dbg, vt[i].we, vt[i].addr, vt[i].wdata, lat, rd, oth, wec);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("vec%0d_other_ack", i), oth, 0);
            chk($sformatf("vec%0d_we_pulses", i), wec, vt[i].we);
        end

        // Both requesters held high: cpu x4, dbg, cpu x4, dbg.
        do_reset();
        set_req(1'b0, 1'b1, 1'b0, 32'h10, '0);
        set_req(1'b1, 1'b1, 1'b1, 32'h40, 32'h77);
        n_acks = 0; both = 0;
        for (int n = 0; n < 200 && n_acks < 10; n++) begin
            @(negedge clk);
            if (ifc.cpu_ack && ifc.dbg_ack) both++;
            if (ifc.cpu_ack || ifc.dbg_ack) begin
                order[n_acks] = ifc.dbg_ack;
                n_acks++;
            end
            if (n_acks < 10) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        chk("starve_ack_count", n_acks, 10);
        chk("starve_dual_ack", both, 0);
        for (int i = 0; i < 10; i++)
            chk($sformatf("starve_order%0d", i), order[i], (i == 4 || i == 9) ? 1 : 0);

        // Debug-only write stream, req held, new fields presented each IDLE cycle.
        set_req(1'b1, 1'b1, 1'b1, 32'h0, 32'h100);
        k = 0;
        for (int n = 0; n < 100 && k < 4; n++) begin
            @(negedge clk);
            if (ifc.dbg_ack) begin
                ack_cyc[k] = n;
                chk($sformatf("stream_starve%0d", k), u_dut.starve_cnt_q, 0);
                k++;
            end
            @(posedge clk); #1;
            if (ifc.dbg_ack == 1'b0 && k > 0 && ack_cyc[k-1] == n)
                set_req(1'b1, 1'b1, 1'b1, AW'(k), DW'(32'h100 + k));
        end
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        chk("stream_acks", k, 4);
        for (int i = 1; i < 4; i++)
            chk($sformatf("stream_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("stream_mem%0d", i), mem[i], 32'h100 + i);

        // Reset during WAIT aborts the read.
        set_req(1'b0, 1'b1, 1'b0, 32'h20, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_busy_in_wait", ifc.busy, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_cpu_ack", ifc.cpu_ack, 0);
        chk("abort_mem_we", ifc.mem_we, 0);
        chk("abort_busy", ifc.busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        run_txn(1'b0, 1'b0, 32'h20, '0, lat, rd, oth, wec);
        chk("abort_next_lat", lat, 3);
        chk("abort_next_rdata", rd, 32'h1234);

        // RD_LAT=3: data only valid in cycle 4, address changed mid-access.
        ifc3.cpu_req = 1; ifc3.cpu_we = 0; ifc3.cpu_addr = 32'h30; rdata3_drv = 32'hBAD0BAD0;
        lat = -1; rd = '0; addr_ok = 1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (n >= 1 && n <= 4 && ifc3.mem_addr != 32'h30) addr_ok = 0;
            if (ifc3.cpu_ack) begin
                lat = n; rd = ifc3.rdata;
                break;
            end
            @(posedge clk); #1;
            if (n == 0) begin ifc3.cpu_addr = 32'h99; ifc3.cpu_we = 1; end
            rdata3_drv = (n + 1 == 4) ? 32'hCAFEF00D : 32'hBAD0BAD0;
        end
        @(posedge clk); #1;
        ifc3.cpu_req = 0;
        chk("lat3_ack_cycle", lat, 5);
        chk("lat3_rdata", rd, 32'hCAFEF00D);
        chk("lat3_addr_held", addr_ok, 1);
        chk("lat3_mem_we", ifc3.mem_we, 0);

        // Randomized traffic against transaction-level model.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            refm[i] = $urandom;
            preload(8'(i), refm[i]);
        end
        c_pend = 0; d_pend = 0; c_ackd = 0; d_ackd = 0;
        prev_ack = -1; mstarve = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (c_ackd) begin c_pend = 0; c_ackd = 0; set_req(1'b0, 1'b0, 1'b0, '0, '0); end
            if (d_ackd) begin d_pend = 0; d_ackd = 0; set_req(1'b1, 1'b0, 1'b0, '0, '0); end
            if (!c_pend && cyc < 2900 && $urandom_range(0, 2) == 0) begin
                ctx.we = 1'($urandom); ctx.a = 4'($urandom); ctx.d = $urandom;
                c_pend = 1; set_req(1'b0, 1'b1, ctx.we, AW'(ctx.a), ctx.d);
            end
            if (!d_pend && cyc < 2900 && $urandom_range(0, 2) == 0) begin
                dtx.we = 1'($urandom); dtx.a = 4'($urandom); dtx.d = $urandom;
                d_pend = 1; set_req(1'b1, 1'b1, dtx.we, AW'(dtx.a), dtx.d);
            end
            @(negedge clk);
            creq_h[cyc] = ifc.cpu_req;
            dreq_h[cyc] = ifc.dbg_req;
            if (ifc.cpu_ack || ifc.dbg_ack) begin
                is_d = ifc.dbg_ack;
                tx = is_d ? dtx : ctx;
                chk("rnd_one_ack", ifc.cpu_ack && ifc.dbg_ack, 0);
                chk("rnd_ack_pending", is_d ? d_pend : c_pend, 1);
                g = cyc - (tx.we ? 2 : 3);
                eg = -1;
                for (int c = prev_ack + 1; c <= cyc && eg < 0; c++)
                    if (creq_h[c] || dreq_h[c]) eg = c;
                chk("rnd_grant_cycle", g, eg);
                if (eg >= 0) begin
                    pick_d = dreq_h[eg] && (!creq_h[eg] || mstarve == SMAX);
                    chk("rnd_owner", is_d, pick_d);
                    if (!pick_d && dreq_h[eg]) mstarve = (mstarve < SMAX) ? mstarve + 1 : SMAX;
                    else mstarve = 0;
                end
                if (tx.we) refm[tx.a] = tx.d;
                else chk("rnd_rdata", ifc.rdata, refm[tx.a]);
                prev_ack = cyc;
                if (is_d) d_ackd = 1; else c_ackd = 1;
            end
            @(posedge clk); #1;
        end
        chk("rnd_drained", {c_pend & !c_ackd, d_pend & !d_ackd}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
